// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: issues word-aligned instruction fetches, buffers one fetched
// instruction for decode and handles branch/jump redirects, including
// redirects that arrive while a fetch is still outstanding.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   input  logic        id_ready
);

   typedef enum logic [1:0] {
      StReq,
      StDrain,
      StHold
   } state_e;

   state_e      state_q, state_d;
   logic        run_q;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_q, pend_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_instr_q, if_instr_d;

   logic [31:0] target;
   logic        ack;

   // Low two bits of a redirect target are dropped, not trusted.
   assign target = redirect_pc & 32'hFFFF_FFFC;

   // run_q holds the request low until the first clock edge after reset release.
   assign imem_req  = run_q & (state_q != StHold);
   assign imem_addr = pc_q;
   assign ack       = imem_req & imem_ack;

   assign if_valid = if_valid_q;
   assign if_pc    = if_pc_q;
   assign if_instr = if_instr_q;

   // State, PC and instruction buffer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StReq;
         run_q      <= 1'b0;
         pc_q       <= RESET_PC;
         pend_q     <= RESET_PC;
         if_valid_q <= 1'b0;
         if_pc_q    <= 32'h0;
         if_instr_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         run_q      <= 1'b1;
         pc_q       <= pc_d;
         pend_q     <= pend_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
      end
   end

   // Next-state logic; a redirect always beats an ack or a decode handshake.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_d     = pend_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;

      if (run_q) begin
         unique case (state_q)
            StReq: begin
               if (redirect_valid) begin
                  if (ack) begin
                     // In-flight data is stale; refetch from the target right away.
                     pc_d = target;
                  end else begin
                     // Address must stay stable until the memory acks.
                     pend_d  = target;
                     state_d = StDrain;
                  end
               end else if (ack) begin
                  if_instr_d = imem_rdata;
                  if_pc_d    = pc_q;
                  if_valid_d = 1'b1;
                  state_d    = StHold;
               end
            end
            StDrain: begin
               if (ack) begin
                  pc_d    = redirect_valid ? target : pend_q;
                  state_d = StReq;
               end else if (redirect_valid) begin
                  pend_d = target;
               end
            end
            StHold: begin
               if (redirect_valid) begin
                  if_valid_d = 1'b0;
                  pc_d       = target;
                  state_d    = StReq;
               end else if (id_ready) begin
                  if_valid_d = 1'b0;
                  pc_d       = pc_q + 32'd4;
                  state_d    = StReq;
               end
            end
            default: begin
               state_d = StReq;
            end
         endcase
      end
   end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 redirect_valid  input  1  SHALL mean a branch/jump redirect is present this cycle.
REQ-005 redirect_pc  input  32  SHALL be the redirect target; bits [1:0] SHALL be ignored and treated as 00.
REQ-006 imem_req  output  1  SHALL be the instruction-memory fetch request.
REQ-007 imem_addr  output  32  SHALL be the fetch address, word aligned.
REQ-008 imem_ack  input  1  SHALL mean imem_rdata is valid for the outstanding request; sampled only while imem_req=1.
REQ-009 imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-010 if_valid  output  1  SHALL mean if_pc/if_instr hold an instruction for decode.
REQ-011 if_pc  output  32  SHALL be the address of if_instr.
REQ-012 if_instr  output  32  SHALL be the buffered instruction.
REQ-013 id_ready  input  1  SHALL mean decode accepts if_instr this cycle; transfer occurs on if_valid & id_ready.

Function
REQ-014 The FSM SHALL have states REQ, DRAIN and HOLD, plus a 32-bit pc register.
REQ-015 In REQ and DRAIN, imem_req SHALL be 1 and imem_addr SHALL equal pc. In HOLD, imem_req SHALL be 0.
REQ-016 While imem_req=1 and imem_ack=0, imem_addr SHALL stay stable.
REQ-017 REQ with imem_ack=1 and no redirect SHALL load imem_rdata into if_instr and pc into if_pc, set if_valid, and go to HOLD (1-cycle ack-to-valid latency).
REQ-018 HOLD with if_valid & id_ready and no redirect SHALL clear if_valid, set pc to pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), and go to REQ; the next request SHALL be asserted the following cycle.
REQ-019 HOLD without id_ready SHALL keep if_valid, if_pc and if_instr unchanged.
REQ-020 Redirect SHALL have priority over every other event; the target SHALL be redirect_pc with bits [1:0] forced to 00.
REQ-021 Redirect in REQ with imem_ack=0 SHALL load pc_pending with the target and go to DRAIN; imem_addr SHALL keep the old pc until ack.
REQ-022 DRAIN with imem_ack=1 SHALL discard imem_rdata, set pc to pc_pending, and go to REQ.
REQ-023 Redirect in DRAIN SHALL overwrite pc_pending, so the last redirect wins.
REQ-024 Redirect in REQ with imem_ack=1 SHALL discard imem_rdata, set pc to the target, and stay in REQ.
REQ-025 Redirect in HOLD SHALL clear if_valid, set pc to the target, and go to REQ; this applies whether or not id_ready is high that cycle.
REQ-026 A redirect coincident with a HOLD id_ready handshake SHALL count as a completed transfer; the next fetch SHALL be the target, not pc+4.
REQ-027 if_valid SHALL never be 1 for data fetched before a redirect.
REQ-028 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-029 While rst_n=0, outputs SHALL be: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0; state SHALL be REQ and pc=RESET_PC.
REQ-030 Assertion of rst_n SHALL take effect immediately, independent of clk, and SHALL abandon any outstanding fetch without waiting for imem_ack.
REQ-031 imem_req SHALL first rise at the first rising clk edge after rst_n deasserts.

Verification
REQ-032 Reset release, ack one cycle after each request, id_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; if_pc follows the same sequence, with if_valid high one cycle after each ack.
REQ-033 id_ready held 0 for 5 cycles after the first ack -> if_valid=1 and if_pc=0x0 stable throughout; imem_req=0; the next request to 0x4 starts the cycle after id_ready rises.
REQ-034 Request to 0x8 outstanding with ack delayed 3 cycles; redirect_pc=0x103 (unaligned) in cycle 1 -> imem_addr stays 0x8 until ack; data discarded; next imem_addr=0x100; if_valid never shows pc 0x8.
REQ-035 Redirect to 0x200, then 0x300, both during DRAIN -> the post-ack request goes to 0x300.
REQ-036 In HOLD with if_pc=0x10, id_ready=1 together with redirect to 0x40 -> one transfer of 0x10; next imem_addr=0x40, not 0x14.
REQ-037 RESET_PC=32'hFFFF_FFFC -> second fetch address 0x0; rst_n asserted mid-request -> imem_req=0 immediately and restart from RESET_PC.
